// File: rtl/connect8_pkg.sv
// Shared definitions for the CONNECT8 board controller: FSM encoding,
// placement error codes and the per-anchor-column out-of-bounds masks.
package connect8_pkg;

    localparam int BOARD_W = 64;

    typedef enum logic [2:0] {
        S_INIT,
        S_GEN,
        S_WAIT,
        S_SCAN,
        S_IDLE,
        S_CHECK,
        S_CLEAR,
        S_OVER
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_PIECE   = 2'd1;
    localparam logic [1:0] ERR_OOB     = 2'd2;
    localparam logic [1:0] ERR_OVERLAP = 2'd3;

    // COLMASK[c] marks columns >= 8-c in every row: a shape with any of these
    // bits set would spill past column 7 when anchored at column c.
    localparam logic [0:7][63:0] COLMASK = {
        64'h0000_0000_0000_0000,
        64'h8080_8080_8080_8080,
        64'hC0C0_C0C0_C0C0_C0C0,
        64'hE0E0_E0E0_E0E0_E0E0,
        64'hF0F0_F0F0_F0F0_F0F0,
        64'hF8F8_F8F8_F8F8_F8F8,
        64'hFCFC_FCFC_FCFC_FCFC,
        64'hFEFE_FEFE_FEFE_FEFE
    };

endpackage

// File: rtl/fit_check.sv
// Combinational fit test of one shape at one anchor against the board.
module fit_check
    import connect8_pkg::*;
(
    input  logic [BOARD_W-1:0] i_shape,
    input  logic [BOARD_W-1:0] i_board,
    input  logic [2:0]         i_row,
    input  logic [2:0]         i_col,
    output logic [BOARD_W-1:0] o_placed,
    output logic               o_oob,
    output logic               o_overlap
);

    logic [6:0] w_row_sh;

    // Shift the shape to its anchor and test column spill, row spill and overlap
    always_comb begin
        w_row_sh  = 7'd64 - {1'b0, i_row, 3'b000};
        o_placed  = i_shape << {i_row, i_col};
        o_oob     = (|(i_shape & COLMASK[i_col])) ||
                    ((i_row != 3'd0) && (|(i_shape >> w_row_sh)));
        o_overlap = |(o_placed & i_board);
    end

endmodule

// File: rtl/board_controller.sv
// CONNECT8 board owner: validates and commits piece placements, clears full
// rows/columns, keeps score, requests new pieces and detects game over.
module board_controller
    import connect8_pkg::*;
#(
    parameter int SCORE_W  = 16,
    parameter int LINE_PTS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BOARD_W-1:0] block1,
    input  logic [BOARD_W-1:0] block2,
    input  logic [BOARD_W-1:0] block3,
    output logic               generate_new,
    input  logic               place_req,
    input  logic [1:0]         place_sel,
    input  logic [2:0]         place_row,
    input  logic [2:0]         place_col,
    output logic               place_ready,
    output logic               place_done,
    output logic               place_err,
    output logic [1:0]         err_code,
    output logic [BOARD_W-1:0] board,
    output logic [2:0]         used,
    output logic [3:0]         lines_cleared,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam int SW = SCORE_W + 9;

    state_e             r_state, w_next;
    logic [BOARD_W-1:0] r_board;
    logic [2:0]         r_used;
    logic [3:0]         r_lines;
    logic [SCORE_W-1:0] r_score;
    logic               r_done, r_err;
    logic [1:0]         r_err_code;
    logic [1:0]         r_sel;
    logic [2:0]         r_row, r_col;
    logic [6:0]         r_cells;
    logic [1:0]         r_scan_p;
    logic [5:0]         r_scan_pos;

    logic               w_scan;
    logic [1:0]         w_idx;
    logic [2:0]         w_fc_row, w_fc_col;
    logic [BOARD_W-1:0] w_shape, w_placed, w_clr;
    logic               w_oob, w_overlap;
    logic [3:0]         w_used4;
    logic [1:0]         w_err_code;
    logic               w_skip, w_scan_fit, w_scan_last;
    logic [7:0]         w_full_row, w_full_col;
    logic [4:0]         w_lines;
    logic [SW-1:0]      w_sum;

    // Share the single fit checker between CHECK (latched request) and SCAN
    always_comb begin
        w_scan   = (r_state == S_SCAN);
        w_idx    = w_scan ? r_scan_p : r_sel;
        w_fc_row = w_scan ? r_scan_pos[5:3] : r_row;
        w_fc_col = w_scan ? r_scan_pos[2:0] : r_col;
        case (w_idx)
            2'd0:    w_shape = block1;
            2'd1:    w_shape = block2;
            2'd2:    w_shape = block3;
            default: w_shape = '0;
        endcase
    end

    fit_check u_fit (
        .i_shape   (w_shape),
        .i_board   (r_board),
        .i_row     (w_fc_row),
        .i_col     (w_fc_col),
        .o_placed  (w_placed),
        .o_oob     (w_oob),
        .o_overlap (w_overlap)
    );

    // Error priority and scan progress; slot 3 reads as permanently used
    always_comb begin
        w_used4 = {1'b1, r_used};
        if (w_used4[r_sel])  w_err_code = ERR_PIECE;
        else if (w_oob)      w_err_code = ERR_OOB;
        else if (w_overlap)  w_err_code = ERR_OVERLAP;
        else                 w_err_code = ERR_OK;
        w_skip      = w_used4[r_scan_p] || (w_shape == '0);
        w_scan_fit  = !w_skip && !w_oob && !w_overlap;
        w_scan_last = (r_scan_p == 2'd2) && (w_skip || (r_scan_pos == 6'd63));
    end

    // Full-line detection, clear mask and saturating score on the post-place board
    always_comb begin
        w_full_row = '0;
        w_full_col = '1;
        w_clr      = '0;
        for (int r = 0; r < 8; r++) begin
            w_full_row[r] = &r_board[r*8 +: 8];
            for (int c = 0; c < 8; c++)
                w_full_col[c] = w_full_col[c] & r_board[r*8+c];
        end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                w_clr[r*8+c] = w_full_row[r] | w_full_col[c];
        w_lines = 5'($countones(w_full_row)) + 5'($countones(w_full_col));
        w_sum   = SW'(r_score) + SW'(r_cells) + SW'(LINE_PTS) * SW'(w_lines);
    end

    // Next-state logic with Moore outputs
    always_comb begin
        w_next       = r_state;
        generate_new = 1'b0;
        place_ready  = 1'b0;
        case (r_state)
            S_INIT:  w_next = S_GEN;
            S_GEN: begin
                generate_new = 1'b1;
                w_next       = S_WAIT;
            end
            S_WAIT:  w_next = S_SCAN;
            S_SCAN: begin
                if (w_scan_fit)       w_next = S_IDLE;
                else if (w_scan_last) w_next = S_OVER;
            end
            S_IDLE: begin
                place_ready = 1'b1;
                if (place_req) w_next = S_CHECK;
            end
            S_CHECK: w_next = (w_err_code != ERR_OK) ? S_IDLE : S_CLEAR;
            S_CLEAR: w_next = (&r_used) ? S_GEN : S_SCAN;
            S_OVER:  w_next = S_OVER;
            default: w_next = S_INIT;
        endcase
    end

    // State register plus board, score and scan bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_board    <= '0;
            r_used     <= '0;
            r_lines    <= '0;
            r_score    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_OK;
            r_sel      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_cells    <= '0;
            r_scan_p   <= '0;
            r_scan_pos <= '0;
        end else begin
            r_state    <= w_next;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_OK;
            case (r_state)
                S_GEN: r_used <= '0;
                S_SCAN: begin
                    if (!w_scan_fit) begin
                        if (w_skip || (r_scan_pos == 6'd63)) begin
                            r_scan_p   <= r_scan_p + 2'd1;
                            r_scan_pos <= '0;
                        end else begin
                            r_scan_pos <= r_scan_pos + 6'd1;
                        end
                    end
                end
                S_IDLE: begin
                    if (place_req) begin
                        r_sel <= place_sel;
                        r_row <= place_row;
                        r_col <= place_col;
                    end
                end
                S_CHECK: begin
                    if (w_err_code != ERR_OK) begin
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
                        r_err_code <= w_err_code;
                    end else begin
                        r_board <= r_board | w_placed;
                        r_used  <= r_used | (3'b001 << r_sel);
                        r_cells <= 7'($countones(w_shape));
                    end
                end
                S_CLEAR: begin
                    r_board <= r_board & ~w_clr;
                    // 16 lines only occurs on a completely full board; the
                    // 4-bit report pins at 15 while the score uses the true count
                    r_lines <= w_lines[4] ? 4'hF : w_lines[3:0];
                    r_score <= (|w_sum[SW-1:SCORE_W]) ? '1 : w_sum[SCORE_W-1:0];
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
            if (r_state != S_SCAN) begin
                r_scan_p   <= '0;
                r_scan_pos <= '0;
            end
        end
    end

    assign board         = r_board;
    assign used          = r_used;
    assign lines_cleared = r_lines;
    assign score         = r_score;
    assign place_done    = r_done;
    assign place_err     = r_err;
    assign err_code      = r_err_code;
    assign game_over     = (r_state == S_OVER);

endmodule

// File: tb/tb_board_controller.sv
// Directed bench for board_controller: placement table plus reset/scan/game-over sequences.
module tb_board_controller;

    logic        clk;
    logic        reset;
    logic [63:0] block1, block2, block3;
    logic        generate_new;
    logic        place_req;
    logic [1:0]  place_sel;
    logic [2:0]  place_row, place_col;
    logic        place_ready, place_done, place_err;
    logic [1:0]  err_code;
    logic [63:0] board;
    logic [2:0]  used;
    logic [3:0]  lines_cleared;
    logic [15:0] score;
    logic        game_over;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [63:0] T_BOARD = 64'hFEFD_FBF7_EFDF_BF7F; // anti-diagonal holes
    localparam logic [63:0] SQ3     = 64'h0000_0000_0007_0707;

    board_controller #(.SCORE_W(16), .LINE_PTS(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .block1        (block1),
        .block2        (block2),
        .block3        (block3),
        .generate_new  (generate_new),
        .place_req     (place_req),
        .place_sel     (place_sel),
        .place_row     (place_row),
        .place_col     (place_col),
        .place_ready   (place_ready),
        .place_done    (place_done),
        .place_err     (place_err),
        .err_code      (err_code),
        .board         (board),
        .used          (used),
        .lines_cleared (lines_cleared),
        .score         (score),
        .game_over     (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [63:0] shape;
        logic [1:0]  sel;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        err;
        logic [1:0]  code;
        logic [63:0] brd;
        logic [3:0]  lines;
        logic [15:0] scr;
        logic [2:0]  usd;
        logic        gen;
    } vec_t;

    vec_t tbl [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " board"}, board, 64'h0);
        chk({tag, " used"}, {61'h0, used}, 64'h0);
        chk({tag, " score"}, {48'h0, score}, 64'h0);
        chk({tag, " lines"}, {60'h0, lines_cleared}, 64'h0);
        chk({tag, " done"}, {63'h0, place_done}, 64'h0);
        chk({tag, " err"}, {63'h0, place_err}, 64'h0);
        chk({tag, " code"}, {62'h0, err_code}, 64'h0);
        chk({tag, " gen"}, {63'h0, generate_new}, 64'h0);
        chk({tag, " ready"}, {63'h0, place_ready}, 64'h0);
        chk({tag, " over"}, {63'h0, game_over}, 64'h0);
    endtask

    // Wait for ready, issue one request, return edges from accept to done
    task automatic do_place(input logic [1:0] sel, input logic [2:0] row, input logic [2:0] col,
                            output int lat, output logic got);
        int n;
        n = 0;
        while (!place_ready && n < 300) begin
            tick();
            n++;
        end
        chk("ready_wait", {63'h0, place_ready}, 64'h1);
        place_req = 1'b1;
        place_sel = sel;
        place_row = row;
        place_col = col;
        tick();
        place_req = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 4) begin
            tick();
            lat++;
            got = place_done;
        end
    endtask

    initial begin
        int   lat;
        logic got;
        int   n;

        reset = 1'b1;
        place_req = 1'b0;
        place_sel = 2'd0;
        place_row = 3'd0;
        place_col = 3'd0;
        block1 = 64'h303;
        block2 = 64'h1;
        block3 = 64'h1;

        // shape, sel, row, col, err, code, board, lines, score, used, gen
        tbl[0]  = '{64'h303, 2'd0, 3'd6, 3'd6, 1'b0, 2'd0, 64'hC0C0_0000_0000_0000, 4'd0, 16'd4,  3'b001, 1'b0};
        tbl[1]  = '{64'h303, 2'd0, 3'd0, 3'd0, 1'b1, 2'd1, 64'hC0C0_0000_0000_0000, 4'd0, 16'd4,  3'b001, 1'b0};
        tbl[2]  = '{64'h1F,  2'd1, 3'd0, 3'd4, 1'b1, 2'd2, 64'hC0C0_0000_0000_0000, 4'd0, 16'd4,  3'b001, 1'b0};
        tbl[3]  = '{64'h1,   2'd1, 3'd6, 3'd6, 1'b1, 2'd3, 64'hC0C0_0000_0000_0000, 4'd0, 16'd4,  3'b001, 1'b0};
        tbl[4]  = '{64'h1,   2'd3, 3'd0, 3'd0, 1'b1, 2'd1, 64'hC0C0_0000_0000_0000, 4'd0, 16'd4,  3'b001, 1'b0};
        tbl[5]  = '{64'h303, 2'd0, 3'd7, 3'd7, 1'b1, 2'd1, 64'hC0C0_0000_0000_0000, 4'd0, 16'd4,  3'b001, 1'b0};
        tbl[6]  = '{64'h101, 2'd1, 3'd7, 3'd0, 1'b1, 2'd2, 64'hC0C0_0000_0000_0000, 4'd0, 16'd4,  3'b001, 1'b0};
        tbl[7]  = '{64'h7F,  2'd1, 3'd0, 3'd0, 1'b0, 2'd0, 64'hC0C0_0000_0000_007F, 4'd0, 16'd11, 3'b011, 1'b0};
        tbl[8]  = '{64'h1,   2'd2, 3'd0, 3'd7, 1'b0, 2'd0, 64'hC0C0_0000_0000_0000, 4'd1, 16'd20, 3'b111, 1'b1};
        tbl[9]  = '{64'h0808_0808_F708_0808, 2'd0, 3'd0, 3'd0, 1'b0, 2'd0,
                    64'hC8C8_0808_F708_0808, 4'd0, 16'd34, 3'b001, 1'b0};
        tbl[10] = '{64'h1,   2'd1, 3'd3, 3'd3, 1'b0, 2'd0, 64'hC0C0_0000_0000_0000, 4'd2, 16'd51, 3'b011, 1'b0};
        tbl[11] = '{64'h303, 2'd2, 3'd6, 3'd6, 1'b1, 2'd3, 64'hC0C0_0000_0000_0000, 4'd2, 16'd51, 3'b011, 1'b0};

        tick();
        tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();
        chk("gen_pulse", {63'h0, generate_new}, 64'h1);
        tick();
        chk("gen_end", {63'h0, generate_new}, 64'h0);

        for (int i = 0; i < 12; i++) begin
            case (tbl[i].sel)
                2'd0:    block1 = tbl[i].shape;
                2'd1:    block2 = tbl[i].shape;
                2'd2:    block3 = tbl[i].shape;
                default: ;
            endcase
            do_place(tbl[i].sel, tbl[i].row, tbl[i].col, lat, got);
            chk($sformatf("v%0d done", i), {63'h0, got}, 64'h1);
            chk($sformatf("v%0d latency", i), 64'(lat), tbl[i].err ? 64'd1 : 64'd2);
            chk($sformatf("v%0d err", i), {63'h0, place_err}, {63'h0, tbl[i].err});
            chk($sformatf("v%0d code", i), {62'h0, err_code}, {62'h0, tbl[i].code});
            chk($sformatf("v%0d board", i), board, tbl[i].brd);
            chk($sformatf("v%0d lines", i), {60'h0, lines_cleared}, {60'h0, tbl[i].lines});
            chk($sformatf("v%0d score", i), {48'h0, score}, {48'h0, tbl[i].scr});
            chk($sformatf("v%0d used", i), {61'h0, used}, {61'h0, tbl[i].usd});
            chk($sformatf("v%0d gen", i), {63'h0, generate_new}, {63'h0, tbl[i].gen});
            if (i == 8) begin
                tick();
                chk("refresh used", {61'h0, used}, 64'h0);
                chk("refresh gen", {63'h0, generate_new}, 64'h0);
            end
        end

        // Board of isolated holes: only 3x3 pieces left for the scan
        block1 = T_BOARD;
        block2 = SQ3;
        block3 = SQ3;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_place(2'd0, 3'd0, 3'd0, lat, got);
        chk("holes done", {63'h0, got}, 64'h1);
        chk("holes board", board, T_BOARD);
        chk("holes score", {48'h0, score}, 64'd56);
        repeat (40) tick();
        chk("scan busy ready", {63'h0, place_ready}, 64'h0);
        chk("scan busy over", {63'h0, game_over}, 64'h0);
        reset = 1'b1;
        tick();
        chk_zero("midscan");
        reset = 1'b0;

        do_place(2'd0, 3'd0, 3'd0, lat, got);
        chk("replay done", {63'h0, got}, 64'h1);
        chk("replay score", {48'h0, score}, 64'd56);
        n = 0;
        while (!game_over && n < 200) begin
            tick();
            n++;
        end
        chk("game_over", {63'h0, game_over}, 64'h1);
        chk("scan cycles", 64'(n), 64'd129);
        chk("over ready", {63'h0, place_ready}, 64'h0);

        place_req = 1'b1;
        place_sel = 2'd1;
        got = 1'b0;
        repeat (4) begin
            tick();
            got = got | place_done;
        end
        place_req = 1'b0;
        chk("over ignores req", {63'h0, got}, 64'h0);
        chk("over board", board, T_BOARD);
        chk("over sticky", {63'h0, game_over}, 64'h1);

        reset = 1'b1;
        tick();
        chk("final over", {63'h0, game_over}, 64'h0);
        chk("final board", board, 64'h0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
